// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong geometry, state encoding and paddle motion helper
package pong_pkg;

    localparam logic [9:0] TELA_L    = 10'd640;
    localparam logic [9:0] TELA_A    = 10'd480;
    localparam logic [9:0] PAREDE    = 10'd6;
    localparam logic [9:0] BOLA_TAM  = 10'd20;
    localparam logic [9:0] BARRA_L   = 10'd15;
    localparam logic [9:0] BARRA_A   = 10'd80;
    localparam logic [9:0] BARRA_E_X = 10'd0;
    localparam logic [9:0] BARRA_D_X = 10'd630;
    localparam logic [9:0] CENTRO_X  = 10'd310;
    localparam logic [9:0] CENTRO_Y  = 10'd230;

    // Derived limits: ball/paddle travel range, bounce columns and the right goal line
    localparam logic [9:0] BOLA_Y_MAX  = TELA_A - BOLA_TAM;
    localparam logic [9:0] BARRA_Y_MAX = TELA_A - BARRA_A;
    localparam logic [9:0] BATE_E      = BARRA_E_X + BARRA_L + 10'd1;
    localparam logic [9:0] BATE_D      = BARRA_D_X - BOLA_TAM;
    localparam logic [9:0] GOL_D       = TELA_L - BOLA_TAM;

    typedef enum logic [2:0] {ESPERA, SAQUE, JOGO, PONTO, FIM} estado_t;

    function automatic logic [9:0] mover_barra(input logic [9:0] y, input logic up,
                                               input logic down, input logic [9:0] vel);
        logic [10:0] soma;
        soma = {1'b0, y} + {1'b0, vel};
        mover_barra = y;
        if (up && !down)
            mover_barra = (y < PAREDE + vel) ? PAREDE : y - vel;
        else if (down && !up)
            mover_barra = (soma >= {1'b0, BARRA_Y_MAX}) ? BARRA_Y_MAX : soma[9:0];
    endfunction

endpackage

// File: rtl/sync_borda.sv
// rtl/sync_borda.sv - 2-FF synchronizer with registered rising-edge pulse
module sync_borda (
    input  logic Clock,
    input  logic Reset,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic s1, s2, s3;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end

    assign level = s2;

endmodule

// File: rtl/pong_logica.sv
// rtl/pong_logica.sv - Pong game-state engine: paddles, ball, scoring and match sequence
module pong_logica
    import pong_pkg::*;
#(
    parameter int VEL_BOLA     = 2,
    parameter int VEL_BARRA    = 4,
    parameter int PLACAR_MAX   = 9,
    parameter int ESPERA_SAQUE = 60
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       VSync,
    input  logic       start,
    input  logic       btn_e_up,
    input  logic       btn_e_down,
    input  logic       btn_d_up,
    input  logic       btn_d_down,
    output logic [9:0] bola_x,
    output logic [9:0] bola_y,
    output logic [9:0] barra_e_y,
    output logic [9:0] barra_d_y,
    output logic [3:0] placar_e,
    output logic [3:0] placar_d
);

    localparam logic [9:0] VB   = 10'(VEL_BOLA);
    localparam logic [9:0] VR   = 10'(VEL_BARRA);
    localparam logic [3:0] PMAX = 4'(PLACAR_MAX);
    localparam int         CW   = $clog2(ESPERA_SAQUE + 1);
    localparam logic [CW-1:0] CNT_FIM = CW'(ESPERA_SAQUE - 1);

    // Index order: VSync, start, e_up, e_down, d_up, d_down
    logic [5:0] entradas, niveis, pulsos;
    logic       unused_sinais;

    assign entradas = {btn_d_down, btn_d_up, btn_e_down, btn_e_up, start, VSync};

    for (genvar i = 0; i < 6; i++) begin : g_sync
        sync_borda u_sync (
            .Clock (Clock),
            .Reset (Reset),
            .din   (entradas[i]),
            .level (niveis[i]),
            .pulse (pulsos[i])
        );
    end

    // Frame and start act on edges, the paddle buttons on levels
    assign unused_sinais = &{1'b0, niveis[1:0], pulsos[5:2]};

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic          dir_x, dir_y, ponto_e;
    logic [10:0]   nx, ny;
    logic          sobre_e, sobre_d, perde_e, perde_d;
    logic          tick, start_p;

    assign tick    = pulsos[0];
    assign start_p = pulsos[1];

    always_comb begin
        nx = dir_x ? {1'b0, bola_x} + {1'b0, VB} : {1'b0, bola_x} - {1'b0, VB};
        ny = dir_y ? {1'b0, bola_y} + {1'b0, VB} : {1'b0, bola_y} - {1'b0, VB};
        sobre_e = ({1'b0, bola_y} + {1'b0, BOLA_TAM} > {1'b0, barra_e_y}) &&
                  ({1'b0, bola_y} < {1'b0, barra_e_y} + {1'b0, BARRA_A});
        sobre_d = ({1'b0, bola_y} + {1'b0, BOLA_TAM} > {1'b0, barra_d_y}) &&
                  ({1'b0, bola_y} < {1'b0, barra_d_y} + {1'b0, BARRA_A});
        // Left miss is decided on the current x so the subtraction above may wrap harmlessly
        perde_e = !dir_x && (bola_x < VB + 10'd1);
        perde_d = dir_x && (nx >= {1'b0, GOL_D}) && !sobre_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado    <= ESPERA;
            cnt       <= '0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            ponto_e   <= 1'b0;
            bola_x    <= CENTRO_X;
            bola_y    <= CENTRO_Y;
            barra_e_y <= 10'd200;
            barra_d_y <= 10'd200;
            placar_e  <= 4'd0;
            placar_d  <= 4'd0;
        end else begin
            case (estado)
                ESPERA: if (start_p) begin
                    estado <= SAQUE;
                    cnt    <= '0;
                end
                SAQUE: if (tick) begin
                    barra_e_y <= mover_barra(barra_e_y, niveis[2], niveis[3], VR);
                    barra_d_y <= mover_barra(barra_d_y, niveis[4], niveis[5], VR);
                    if (cnt == CNT_FIM) begin
                        estado <= JOGO;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                JOGO: if (tick) begin
                    barra_e_y <= mover_barra(barra_e_y, niveis[2], niveis[3], VR);
                    barra_d_y <= mover_barra(barra_d_y, niveis[4], niveis[5], VR);
                    if (perde_e || perde_d) begin
                        estado  <= PONTO;
                        ponto_e <= perde_d;
                    end else begin
                        if (!dir_x && nx <= {1'b0, BATE_E} && sobre_e) begin
                            bola_x <= BATE_E;
                            dir_x  <= 1'b1;
                        end else if (dir_x && nx >= {1'b0, BATE_D} && sobre_d) begin
                            bola_x <= BATE_D;
                            dir_x  <= 1'b0;
                        end else begin
                            bola_x <= nx[9:0];
                        end
                        if (ny <= {1'b0, PAREDE}) begin
                            bola_y <= PAREDE;
                            dir_y  <= 1'b1;
                        end else if (ny >= {1'b0, BOLA_Y_MAX}) begin
                            bola_y <= BOLA_Y_MAX;
                            dir_y  <= 1'b0;
                        end else begin
                            bola_y <= ny[9:0];
                        end
                    end
                end
                PONTO: begin
                    bola_x <= CENTRO_X;
                    bola_y <= CENTRO_Y;
                    cnt    <= '0;
                    // Serve goes toward the player who just conceded
                    if (ponto_e) begin
                        placar_e <= placar_e + 4'd1;
                        dir_x    <= 1'b1;
                        estado   <= (placar_e + 4'd1 == PMAX) ? FIM : SAQUE;
                    end else begin
                        placar_d <= placar_d + 4'd1;
                        dir_x    <= 1'b0;
                        estado   <= (placar_d + 4'd1 == PMAX) ? FIM : SAQUE;
                    end
                end
                FIM: if (start_p) begin
                    placar_e <= 4'd0;
                    placar_d <= 4'd0;
                    cnt      <= '0;
                    estado   <= SAQUE;
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule
